// File: rtl/shift_iter_unit.sv
// Iterative shift engine: one single-bit shift per clock behind a valid/ready
// request port and a valid/ready result port (SHL, SHR, SSHR, SSHL).
module shift_iter_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SH_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_a,
    input  logic [SH_W-1:0]  in_amt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    localparam int WW = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int CW = $clog2(WW + 1);

    localparam logic [1:0] OP_SHL  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SSHR = 2'b10;
    localparam logic [1:0] OP_SSHL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [WW-1:0]   r_work;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_op;

    logic [WW-1:0]   w_ext;
    logic [CW-1:0]   w_cnt;
    logic [WW-1:0]   w_step;

    // Signed ops (op[1] set) sign-extend the operand into the working register.
    always_comb begin
        w_ext = WW'(in_a);
        if (in_op[1]) begin
            w_ext = WW'($signed(in_a));
        end
    end

    // Amounts at or beyond the working width saturate to a full shift-out.
    always_comb begin
        w_cnt = CW'(WW);
        if (32'(in_amt) < WW) begin
            w_cnt = CW'(in_amt);
        end
    end

    always_comb begin
        w_step = r_work;
        case (r_op)
            OP_SHL, OP_SSHL: w_step = {r_work[WW-2:0], 1'b0};
            OP_SHR:          w_step = {1'b0, r_work[WW-1:1]};
            OP_SSHR:         w_step = {r_work[WW-1], r_work[WW-1:1]};
            default:         w_step = r_work;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= OP_SHL;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= w_ext;
                        r_cnt   <= w_cnt;
                        r_op    <= in_op;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt != '0) begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt - CW'(1);
                    end else begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_data  = r_work[OUT_W-1:0];

endmodule

// File: tb/tb_shift_iter_unit.sv
// Bench for shift_iter_unit: directed and random requests on a 16->8 instance
// and a 4->8 instance, checked against an arithmetic shift model.
module tb_shift_iter_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] inA = '0;
    logic [3:0]  inAmt = '0;
    logic [1:0]  inOp = '0;
    logic        outValid;
    logic        outReady = 1'b1;
    logic [7:0]  outData;

    logic        inValid4 = 1'b0;
    logic        inReady4;
    logic [3:0]  inA4 = '0;
    logic [3:0]  inAmt4 = '0;
    logic [1:0]  inOp4 = '0;
    logic        outValid4;
    logic        outReady4 = 1'b1;
    logic [7:0]  outData4;

    int vectors = 0;
    int miscompares = 0;

    shift_iter_unit #(.IN_W(16), .OUT_W(8), .SH_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_amt(inAmt), .in_op(inOp),
        .out_valid(outValid), .out_ready(outReady), .out_data(outData)
    );

    shift_iter_unit #(.IN_W(4), .OUT_W(8), .SH_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(inValid4), .in_ready(inReady4),
        .in_a(inA4), .in_amt(inAmt4), .in_op(inOp4),
        .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4)
    );

    always #5 clk = ~clk;

    // Shift rules expressed as integer arithmetic on an extended operand.
    function automatic logic [7:0] model(input logic [15:0] a, input int amt,
                                         input logic [1:0] op, input int inw);
        int     ww;
        int     n;
        longint v;
        longint r;
        ww = (inw > 8) ? inw : 8;
        n  = (amt < ww) ? amt : ww;
        v  = longint'(a) & ((longint'(1) << inw) - 1);
        if (op[1] && a[inw-1]) v = v - (longint'(1) << inw);
        case (op)
            2'b00, 2'b11: r = v * (longint'(1) << n);
            2'b01:        r = (v & ((longint'(1) << ww) - 1)) / (longint'(1) << n);
            default:      r = v >>> n;
        endcase
        return r[7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
        @(negedge clk);
        checkOutput("ready_before_issue", 32'(inReady), 32'd1);
        inValid = 1'b1;
        inA     = a;
        inAmt   = amt;
        inOp    = op;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inA     = 16'($urandom);
        inAmt   = 4'($urandom);
        inOp    = 2'($urandom);
    endtask

    task automatic waitResult(input string tag, input int expLat, input logic [7:0] expData);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!outValid && cycles < 64);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, "_data"}, 32'(outData), 32'(expData));
        if (outReady) begin
            @(posedge clk);
            #1;
            checkOutput({tag, "_ready_after"}, 32'(inReady), 32'd1);
        end
    endtask

    task automatic runOp4(input string tag, input logic [3:0] a, input logic [3:0] amt,
                          input logic [1:0] op, input logic [7:0] expData);
        int cycles;
        @(negedge clk);
        inValid4 = 1'b1;
        inA4     = a;
        inAmt4   = amt;
        inOp4    = op;
        @(posedge clk);
        #1;
        inValid4 = 1'b0;
        inA4     = 4'($urandom);
        cycles   = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!outValid4 && cycles < 64);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'((amt < 8) ? amt + 1 : 9));
        checkOutput({tag, "_data"}, 32'(outData4), 32'(expData));
        @(posedge clk);
        #1;
    endtask

    logic [15:0] dirA   [8] = '{16'hABCD, 16'h8000, 16'h8000, 16'h8000, 16'h0001, 16'h0001, 16'h00A5, 16'hFFFF};
    logic [3:0]  dirAmt [8] = '{4'd4, 4'd15, 4'd15, 4'd15, 4'd7, 4'd8, 4'd0, 4'd15};
    logic [1:0]  dirOp  [8] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [7:0]  dirExp [8] = '{8'hBC, 8'hFF, 8'h01, 8'h00, 8'h80, 8'h00, 8'hA5, 8'h00};
    logic [1:0]  op4    [4] = '{2'b10, 2'b01, 2'b11, 2'b00};
    logic [7:0]  exp4   [4] = '{8'hFD, 8'h05, 8'hF4, 8'h14};

    initial begin
        logic [15:0] ra;
        logic [3:0]  ramt;
        logic [1:0]  rop;
        int          seen;

        #12;
        checkOutput("reset_in_ready", 32'(inReady), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid), 32'd0);
        checkOutput("reset_out_data", 32'(outData), 32'd0);
        checkOutput("reset_in_ready4", 32'(inReady4), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(dirA[i], dirAmt[i], dirOp[i]);
            waitResult($sformatf("dir%0d", i), int'(dirAmt[i]) + 1, dirExp[i]);
        end

        for (int i = 0; i < 4; i++) begin
            runOp4($sformatf("w4_dir%0d", i), 4'hA, 4'd1, op4[i], exp4[i]);
        end

        for (int i = 0; i < 24; i++) begin
            ra   = 16'($urandom);
            ramt = 4'($urandom_range(0, 15));
            rop  = 2'($urandom_range(0, 3));
            applyStimulus(ra, ramt, rop);
            waitResult($sformatf("rand%0d", i), int'(ramt) + 1, model(ra, int'(ramt), rop, 16));
        end

        for (int i = 0; i < 12; i++) begin
            ra   = 16'($urandom_range(0, 15));
            ramt = 4'($urandom_range(0, 15));
            rop  = 2'($urandom_range(0, 3));
            runOp4($sformatf("w4_rand%0d", i), ra[3:0], ramt, rop, model(ra, int'(ramt), rop, 4));
        end

        outReady = 1'b0;
        applyStimulus(16'h1234, 4'd3, 2'b00);
        waitResult("bp", 4, 8'hA0);
        @(negedge clk);
        inValid = 1'b1;
        inA     = 16'h00F0;
        inAmt   = 4'd1;
        inOp    = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_hold_valid", 32'(outValid), 32'd1);
            checkOutput("bp_hold_data", 32'(outData), 32'hA0);
            checkOutput("bp_hold_ready", 32'(inReady), 32'd0);
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_handoff_ready", 32'(inReady), 32'd1);
        checkOutput("bp_handoff_valid", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("bp_accept", 32'(inReady), 32'd0);
        inValid = 1'b0;
        waitResult("bp_next", 2, 8'h78);

        applyStimulus(16'h5A5A, 4'd10, 2'b01);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(outValid), 32'd0);
        checkOutput("rst_in_ready", 32'(inReady), 32'd1);
        checkOutput("rst_out_data", 32'(outData), 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (outValid) seen++;
        end
        checkOutput("rst_no_stale", 32'(seen), 32'd0);
        applyStimulus(16'hC3C3, 4'd2, 2'b10);
        waitResult("post_rst", 3, 8'hF0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
